// File: rtl/plic_define.sv
// Shared PLIC definitions: source count, ID width, nesting depth and the
// target-side claim/complete FSM state encoding.
package plic_define;

    localparam int PLIC_IRQ_NUM    = 32;
    localparam int PLIC_IRQ_WIDTH  = $clog2(PLIC_IRQ_NUM);
    localparam int PLIC_NEST_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLAIM = 2'd1,
        COMP  = 2'd2,
        WAIT  = 2'd3
    } plic_tgt_state_e;

endpackage

// File: rtl/dffr.sv
// Generic D flop with asynchronous active-high reset to RST_VAL.
// Ports: clk_i, rst_i, d_i (next value), q_o (registered value).
module dffr #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) q_o <= RST_VAL;
        else       q_o <= d_i;
    end

endmodule

// File: rtl/plic_isr_stack.sv
// LIFO of in-service interrupt IDs for one target.
// Ports: clk_i/rst_i, push_i + push_id_i, pop_i, top_o (0 when empty),
// depth_o, full_o, empty_o. Push and pop are never asserted together.
module plic_isr_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               push_id_i,
    input  logic                       pop_i,
    output logic [W-1:0]               top_o,
    output logic [$clog2(DEPTH+1)-1:0] depth_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int DW = $clog2(DEPTH+1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [0:(1<<IW)-1];
    logic [DW-1:0] r_depth;
    logic [DW-1:0] w_dm1;

    assign w_dm1   = r_depth - DW'(1);
    assign full_o  = (r_depth == DW'(DEPTH));
    assign empty_o = (r_depth == '0);
    assign top_o   = empty_o ? '0 : r_mem[w_dm1[IW-1:0]];
    assign depth_o = r_depth;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                 r_depth <= '0;
        else if (push_i && !full_o) r_depth <= r_depth + DW'(1);
        else if (pop_i && !empty_o) r_depth <= w_dm1;
    end

    // Entries above depth are don't-care, so storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) r_mem[r_depth[IW-1:0]] <= push_id_i;
    end

endmodule

// File: rtl/plic_target.sv
// PLIC per-target claim/complete agent.
// Inputs: irq_i/id_i from the core, claim_req_i and comp_req_i/comp_id_i from
// the hart (four-phase handshake). Outputs: clam_o/comp_o/comp_id_o pulses to
// core and gateways, eip_o to the hart, claim_ack_o/claim_id_o and
// comp_ack_o/comp_err_o handshake responses, depth_o nesting depth.
module plic_target
    import plic_define::*;
#(
    parameter int IRQ_NUM    = PLIC_IRQ_NUM,
    parameter int IRQ_WIDTH  = $clog2(IRQ_NUM),
    parameter int NEST_DEPTH = PLIC_NEST_DEPTH
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            irq_i,
    input  logic [IRQ_WIDTH-1:0]            id_i,
    output logic                            clam_o,
    output logic                            comp_o,
    output logic [IRQ_WIDTH-1:0]            comp_id_o,
    output logic                            eip_o,
    input  logic                            claim_req_i,
    output logic                            claim_ack_o,
    output logic [IRQ_WIDTH-1:0]            claim_id_o,
    input  logic                            comp_req_i,
    input  logic [IRQ_WIDTH-1:0]            comp_id_i,
    output logic                            comp_ack_o,
    output logic                            comp_err_o,
    output logic [$clog2(NEST_DEPTH+1)-1:0] depth_o
);

    logic [1:0]           w_state_q;
    plic_tgt_state_e      r_state, w_state_nxt;
    logic [IRQ_WIDTH-1:0] r_cid, w_cid_d;
    logic [IRQ_WIDTH-1:0] r_ctop, w_ctop_d;
    logic                 r_ok, w_ok_d;
    logic                 w_eip_d;
    logic [IRQ_WIDTH-1:0] w_top;
    logic                 w_full, w_empty, w_push, w_pop;

    assign r_state = plic_tgt_state_e'(w_state_q);

    dffr #(.W(2))         u_state (.clk_i, .rst_i, .d_i(w_state_nxt), .q_o(w_state_q));
    dffr #(.W(IRQ_WIDTH)) u_cid   (.clk_i, .rst_i, .d_i(w_cid_d),     .q_o(r_cid));
    dffr #(.W(IRQ_WIDTH)) u_ctop  (.clk_i, .rst_i, .d_i(w_ctop_d),    .q_o(r_ctop));
    dffr #(.W(1))         u_ok    (.clk_i, .rst_i, .d_i(w_ok_d),      .q_o(r_ok));
    dffr #(.W(1))         u_eip   (.clk_i, .rst_i, .d_i(w_eip_d),     .q_o(eip_o));

    always_comb begin
        w_state_nxt = r_state;
        w_cid_d     = r_cid;
        w_ok_d      = r_ok;
        w_ctop_d    = r_ctop;
        case (r_state)
            IDLE: begin
                if (claim_req_i) begin
                    w_state_nxt = CLAIM;
                    w_cid_d     = (irq_i && !w_full) ? id_i : '0;
                end else if (comp_req_i) begin
                    w_state_nxt = COMP;
                    // Stack never holds ID 0, but guard explicitly anyway.
                    w_ok_d      = !w_empty && (comp_id_i == w_top) && (comp_id_i != '0);
                    w_ctop_d    = w_top;
                end
            end
            CLAIM, COMP: w_state_nxt = WAIT;
            // Held requests must drop before re-arming: core irq/id lag a claim.
            WAIT: if (!claim_req_i && !comp_req_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gating on the next state too keeps eip low from the edge that leaves IDLE.
    assign w_eip_d = irq_i && (r_state == IDLE) && (w_state_nxt == IDLE) && !w_full;

    assign claim_ack_o = (r_state == CLAIM);
    assign claim_id_o  = claim_ack_o ? r_cid : '0;
    assign clam_o      = claim_ack_o && (r_cid != '0);
    assign comp_ack_o  = (r_state == COMP);
    assign comp_err_o  = comp_ack_o && !r_ok;
    assign comp_o      = comp_ack_o && r_ok;
    assign comp_id_o   = comp_o ? r_ctop : '0;

    assign w_push = clam_o;
    assign w_pop  = comp_o;

    plic_isr_stack #(.DEPTH(NEST_DEPTH), .W(IRQ_WIDTH)) u_stack (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (w_push),
        .push_id_i (r_cid),
        .pop_i     (w_pop),
        .top_o     (w_top),
        .depth_o   (depth_o),
        .full_o    (w_full),
        .empty_o   (w_empty)
    );

endmodule

// File: tb/tb_plic_target.sv
module tb_plic_target;

    localparam int IW = 5;
    localparam int DW = 3;
    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          irq_i = 1'b0;
    logic [IW-1:0] id_i = '0;
    logic          claim_req_i = 1'b0;
    logic          comp_req_i = 1'b0;
    logic [IW-1:0] comp_id_i = '0;
    logic          clam_o, comp_o, eip_o, claim_ack_o, comp_ack_o, comp_err_o;
    logic [IW-1:0] comp_id_o, claim_id_o;
    logic [DW-1:0] depth_o;

    plic_target dut (
        .clk_i(clk), .rst_i(rst), .irq_i(irq_i), .id_i(id_i),
        .clam_o(clam_o), .comp_o(comp_o), .comp_id_o(comp_id_o), .eip_o(eip_o),
        .claim_req_i(claim_req_i), .claim_ack_o(claim_ack_o), .claim_id_o(claim_id_o),
        .comp_req_i(comp_req_i), .comp_id_i(comp_id_i), .comp_ack_o(comp_ack_o),
        .comp_err_o(comp_err_o), .depth_o(depth_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_claim;
        logic [IW-1:0] id;
        bit            pulse;
        bit            err;
    } exp_t;

    exp_t          sb[$];
    logic [IW-1:0] mstk[$];   // reference in-service stack
    int n_tot = 0, n_bad = 0, n_clam = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every ack pops one expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (clam_o) n_clam++;
        if (claim_ack_o || comp_ack_o) begin
            if (sb.size() == 0) chk("unexpected_ack", {30'd0, claim_ack_o, comp_ack_o}, 0);
            else begin
                e = sb.pop_front();
                if (e.is_claim) begin
                    chk("claim_ack", claim_ack_o, 1);
                    chk("claim_id", claim_id_o, e.id);
                    chk("clam", clam_o, e.pulse);
                    chk("comp_ack_in_claim", comp_ack_o, 0);
                end else begin
                    chk("comp_ack", comp_ack_o, 1);
                    chk("comp_err", comp_err_o, e.err);
                    chk("comp_o", comp_o, e.pulse);
                    chk("comp_id", comp_id_o, e.pulse ? e.id : '0);
                end
            end
        end else if (claim_id_o != 0 || clam_o || comp_o || comp_id_o != 0 || comp_err_o)
            chk("stray_out", {claim_id_o, clam_o, comp_o, comp_id_o, comp_err_o}, 0);
    end

    task automatic wait_ack(input bit claim, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (claim ? claim_ack_o : comp_ack_o) begin ok = 1; break; end
        end
    endtask

    // Leaves caller at the negedge inside the ack cycle.
    task automatic do_claim(input logic irq, input logic [IW-1:0] id);
        exp_t e;
        bit ok;
        @(negedge clk);
        irq_i = irq; id_i = id;
        e.is_claim = 1; e.err = 0;
        e.id = (irq && mstk.size() < ND) ? id : '0;
        e.pulse = (e.id != 0);
        sb.push_back(e);
        if (e.pulse) mstk.push_back(e.id);
        claim_req_i = 1;
        wait_ack(1, ok);
        chk("claim_timeout", {31'd0, ok}, 1);
        claim_req_i = 0;
    endtask

    task automatic do_comp(input logic [IW-1:0] id);
        exp_t e;
        bit ok;
        @(negedge clk);
        comp_id_i = id;
        e.is_claim = 0;
        e.pulse = (mstk.size() > 0) && (id != 0) && (id == mstk[$]);
        e.err = !e.pulse;
        e.id = id;
        sb.push_back(e);
        if (e.pulse) void'(mstk.pop_back());
        comp_req_i = 1;
        wait_ack(0, ok);
        chk("comp_timeout", {31'd0, ok}, 1);
        comp_req_i = 0;
    endtask

    // From the ack negedge: through WAIT and one IDLE edge so eip is current.
    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        int n0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {clam_o, comp_o, comp_id_o, eip_o, claim_ack_o, claim_id_o, comp_ack_o, comp_err_o}, 0);
        chk("rst_depth", depth_o, 0);
        rst = 0;

        // Idle with a pending irq raises eip one cycle later.
        irq_i = 1; id_i = 5;
        repeat (2) @(negedge clk);
        chk("eip_idle", eip_o, 1);

        // Claim 5 then nest 9.
        do_claim(1, 5);
        @(negedge clk);
        chk("eip_in_wait", eip_o, 0);
        chk("depth_1", depth_o, 1);
        repeat (2) @(negedge clk);
        chk("eip_after_wait", eip_o, 1);
        do_claim(1, 9); settle();
        chk("depth_2", depth_o, 2);

        // Out-of-order completion rejected, then strict LIFO order.
        do_comp(5); settle();
        chk("depth_still_2", depth_o, 2);
        do_comp(9); settle();
        do_comp(5); settle();
        chk("depth_0", depth_o, 0);

        // Spurious claim and invalid completions on an empty stack.
        do_claim(0, 12); settle();
        chk("spurious_depth", depth_o, 0);
        do_comp(3); settle();
        do_comp(0); settle();

        // Fill the stack, then overflow claim returns 0.
        for (int i = 1; i <= 4; i++) begin do_claim(1, IW'(i)); settle(); end
        chk("depth_full", depth_o, 4);
        do_claim(1, 7); settle();
        chk("eip_full", eip_o, 0);
        chk("depth_full_hold", depth_o, 4);
        for (int i = 4; i >= 1; i--) begin do_comp(IW'(i)); settle(); end
        chk("depth_drained", depth_o, 0);

        // Simultaneous requests: claim wins, complete ignored while held.
        begin : simul
            exp_t e;
            bit ok;
            @(negedge clk);
            irq_i = 1; id_i = 6; comp_id_i = 6;
            e.is_claim = 1; e.id = 6; e.pulse = 1; e.err = 0;
            sb.push_back(e); mstk.push_back(6);
            claim_req_i = 1; comp_req_i = 1;
            wait_ack(1, ok);
            chk("simul_timeout", {31'd0, ok}, 1);
            repeat (3) @(negedge clk);
            claim_req_i = 0; comp_req_i = 0;
            settle();
            chk("simul_depth", depth_o, 1);
        end
        do_comp(6); settle();

        // A claim held for 10 cycles produces exactly one pulse.
        begin : held
            exp_t e;
            n0 = n_clam;
            @(negedge clk);
            irq_i = 1; id_i = 11;
            e.is_claim = 1; e.id = 11; e.pulse = 1; e.err = 0;
            sb.push_back(e); mstk.push_back(11);
            claim_req_i = 1;
            repeat (10) @(negedge clk);
            claim_req_i = 0;
            settle();
            chk("held_one_clam", n_clam - n0, 1);
            chk("held_depth", depth_o, 1);
        end

        // Async reset in the middle of a claim.
        @(negedge clk);
        irq_i = 1; id_i = 3; claim_req_i = 1;
        @(posedge clk); #1;
        chk("pre_rst_ack", claim_ack_o, 1);
        rst = 1; #1;
        chk("midrst_outs", {clam_o, comp_o, comp_id_o, eip_o, claim_ack_o, claim_id_o, comp_ack_o, comp_err_o}, 0);
        chk("midrst_depth", depth_o, 0);
        mstk.delete();
        @(negedge clk);
        claim_req_i = 0;
        @(negedge clk);
        rst = 0;
        do_claim(1, 8); settle();
        chk("post_rst_depth", depth_o, 1);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
